sdram_init_checker: RTL and testbench
=====================================

# sdram_init_checker

Synthesizable SDRAM-side responder for the power-up initialization protocol. It sits on the controller's command bus ({CS#,RAS#,CAS#,WE#}, bank, address), where the memory device would sit. It checks the sequence: power-up NOP wait, precharge-all, auto-refreshes, mode-register set, and the wait after each command. It captures the programmed mode register and reports device-ready, or the first protocol violation, to simulation and on-chip debug logic.

## Interface
Parameters:
- T_WAIT, 20000: minimum power-up cycles of NOP/deselect before the first command (200 µs at 100 MHz).
- TRP, 2: minimum NOP cycles after PRECHARGE.
- TRFC, 7: minimum NOP cycles after AUTO REFRESH.
- TMRD, 3: minimum NOP cycles after MODE REGISTER SET.
- AR_MIN, 8: minimum auto-refresh count before MRS.

Ports:
- init_clk  in  1  clock, 100 MHz.
- init_rst_n  in  1  reset, asynchronous, active-low.
- cmd_in  in  4  {CS#,RAS#,CAS#,WE#}.
- bank_in  in  2  bank address.
- addr_in  in  13  address A12..A0.
- dev_ready  out  1  initialization completed legally; sticky.
- err  out  1  protocol violation seen; sticky.
- err_code  out  3  code of the first violation.
- ar_count  out  4  auto-refreshes accepted; saturates at 15.
- mode_reg  out  13  captured MRS address value.
- cas_latency  out  3  mode_reg[6:4].
- burst_len  out  3  mode_reg[2:0].

## Operation
- Command decode:
  - NOP = 0111. Any cmd_in[3]=1 (deselect) is also treated as NOP.
  - PRE = 0010.
  - AREF = 0001.
  - MRS = 0000.
  - Every other CS#-low code is ILLEGAL.
- Error codes:
  - 1 EARLY: command before T_WAIT elapsed.
  - 2 PRE_PART: PRE with A10=0.
  - 3 SEQ: wrong or illegal command for the current state.
  - 4 TIMING: tRP/tRFC/tMRD violated.
  - 5 AR_SHORT: MRS with ar_count < AR_MIN.
  - 6 MODE_BAD: illegal mode value.
- Counters:
  - wait_cnt: 15-bit, increments every cycle from reset, saturates at T_WAIT.
  - gap_cnt: 4-bit, counts NOP cycles since the last command, saturates at 15, cleared when a command is accepted.
- FSM states: PWR, TRP, TRFC, TMRD, READY, ERR.
- PWR:
  - NOP: stay.
  - Non-NOP with wait_cnt < T_WAIT: ERR, code 1.
  - PRE with A10=1: TRP.
  - PRE with A10=0: ERR, code 2.
  - Any other command: ERR, code 3.
- TRP:
  - NOP: increment gap_cnt.
  - Non-NOP with gap_cnt < TRP: ERR, code 4.
  - AREF: go to TRFC, ar_count+1.
  - Any other command: ERR, code 3.
- TRFC:
  - NOP: increment gap_cnt.
  - Non-NOP with gap_cnt < TRFC: ERR, code 4. The timing check takes priority over all others.
  - AREF: stay in TRFC, ar_count+1.
  - MRS with ar_count < AR_MIN: ERR, code 5.
  - MRS with CL ∉ {010, 011}, BL ∉ {000, 001, 010, 011, 111}, or bank_in ≠ 00: ERR, code 6.
  - Legal MRS: capture addr_in into mode_reg, go to TMRD.
  - Any other command: ERR, code 3.
- TMRD:
  - NOP: increment gap_cnt.
  - The TMRD-th NOP moves to READY.
  - Non-NOP before that: ERR, code 4.
- READY: dev_ready=1; all inputs are ignored.
- ERR: err=1. err_code, ar_count and mode_reg freeze. Only reset exits.
- ar_count does not clear on errors.

## Timing
- Inputs are sampled on the rising edge of init_clk. All outputs are registered and change on the same edge that samples the causing input, so they are visible one cycle after the bus value.
- Reset values: dev_ready=0, err=0, err_code=0, ar_count=0, mode_reg=0, cas_latency=0, burst_len=0, state=PWR, wait_cnt=0, gap_cnt=0.
- The earliest legal PRE is the sample on which wait_cnt==T_WAIT, i.e. the (T_WAIT+1)-th edge after reset release.
- Legal gaps: PRE → AREF needs ≥TRP NOP samples in between; AREF → AREF or MRS needs ≥TRFC; MRS → ready needs TMRD NOPs.
- dev_ready rises on the edge that samples the TMRD-th NOP after MRS.
- err rises on the edge that samples the offending command. Only the first error is recorded.
- Reset asserted mid-sequence returns all outputs to reset values asynchronously. The full T_WAIT must elapse again.

## Test plan
- Legal sequence: T_WAIT NOPs, PRE with addr=0x1FFF, 2 NOPs, 8×(AREF + 7 NOPs), MRS with addr=0x0037 bank=00, 3 NOPs -> dev_ready=1, err=0, ar_count=8, cas_latency=3, burst_len=7, mode_reg=0x0037.
- PRE issued at cycle 100 after reset -> err=1, err_code=1, dev_ready stays 0.
- AREF one NOP after PRE -> err_code=4. A later legal-looking MRS leaves err_code=4.
- Legal flow but MRS after only 7 refreshes -> err_code=5, mode_reg=0.
- MRS with addr=0x0017 (CL=001) after 8 refreshes -> err_code=6.
- Reset pulsed during TRFC of refresh 4 -> all outputs 0 immediately. A subsequent PRE before T_WAIT -> err_code=1. A full legal sequence after a second reset -> dev_ready=1.

Source files
------------

// File: rtl/sdram_init_checker.sv
// SDRAM-side responder that checks the power-up initialization command sequence,
// captures the programmed mode register and reports ready or the first violation.
module sdram_init_checker #(
    parameter int unsigned T_WAIT = 20000,
    parameter int unsigned TRP    = 2,
    parameter int unsigned TRFC   = 7,
    parameter int unsigned TMRD   = 3,
    parameter int unsigned AR_MIN = 8
) (
    input  logic        init_clk,
    input  logic        init_rst_n,
    input  logic [3:0]  cmd_in,
    input  logic [1:0]  bank_in,
    input  logic [12:0] addr_in,
    output logic        dev_ready,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [3:0]  ar_count,
    output logic [12:0] mode_reg,
    output logic [2:0]  cas_latency,
    output logic [2:0]  burst_len
);

    localparam int unsigned WAIT_W = 15;
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned ARC_W  = 4;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned CODE_W = 3;

    localparam logic [CODE_W-1:0] E_EARLY    = 3'd1;
    localparam logic [CODE_W-1:0] E_PRE_PART = 3'd2;
    localparam logic [CODE_W-1:0] E_SEQ      = 3'd3;
    localparam logic [CODE_W-1:0] E_TIMING   = 3'd4;
    localparam logic [CODE_W-1:0] E_AR_SHORT = 3'd5;
    localparam logic [CODE_W-1:0] E_MODE_BAD = 3'd6;

    typedef enum logic [2:0] {
        S_PWR, S_TRP, S_TRFC, S_TMRD, S_READY, S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [ARC_W-1:0]    ar_cnt_q, ar_cnt_d;
    logic [ADDR_W-1:0]   mode_q, mode_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;

    logic                is_nop, is_pre, is_aref, is_mrs;
    logic                mode_ok;
    logic [GAP_W-1:0]    gap_inc;
    logic [ARC_W-1:0]    ar_inc;
    logic                fail;
    logic [CODE_W-1:0]   fail_code;

    // Command decode: any deselect (CS# high) counts as a NOP.
    always_comb begin
        is_nop  = cmd_in[3] || (cmd_in == 4'b0111);
        is_pre  = (cmd_in == 4'b0010);
        is_aref = (cmd_in == 4'b0001);
        is_mrs  = (cmd_in == 4'b0000);
        mode_ok = ((addr_in[6:4] == 3'd2) || (addr_in[6:4] == 3'd3)) &&
                  ((addr_in[2:0] <= 3'd3) || (addr_in[2:0] == 3'd7)) &&
                  (bank_in == 2'b00);
        gap_inc = (gap_cnt_q == {GAP_W{1'b1}}) ? gap_cnt_q : gap_cnt_q + GAP_W'(1);
        ar_inc  = (ar_cnt_q == {ARC_W{1'b1}}) ? ar_cnt_q : ar_cnt_q + ARC_W'(1);
    end

    // Next-state logic; violations are collected in fail/fail_code and applied once.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = (wait_cnt_q == WAIT_W'(T_WAIT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        gap_cnt_d  = gap_cnt_q;
        ar_cnt_d   = ar_cnt_q;
        mode_d     = mode_q;
        code_d     = code_q;
        err_d      = err_q;
        ready_d    = ready_q;
        fail       = 1'b0;
        fail_code  = '0;

        case (state_q)
            S_PWR: begin
                if (is_nop) begin
                    gap_cnt_d = gap_inc;
                end else if (wait_cnt_q < WAIT_W'(T_WAIT)) begin
                    fail = 1'b1; fail_code = E_EARLY;
                end else if (is_pre && addr_in[10]) begin
                    state_d   = S_TRP;
                    gap_cnt_d = '0;
                end else if (is_pre) begin
                    fail = 1'b1; fail_code = E_PRE_PART;
                end else begin
                    fail = 1'b1; fail_code = E_SEQ;
                end
            end
            S_TRP: begin
                if (is_nop) begin
                    gap_cnt_d = gap_inc;
                end else if (gap_cnt_q < GAP_W'(TRP)) begin
                    fail = 1'b1; fail_code = E_TIMING;
                end else if (is_aref) begin
                    state_d   = S_TRFC;
                    gap_cnt_d = '0;
                    ar_cnt_d  = ar_inc;
                end else begin
                    fail = 1'b1; fail_code = E_SEQ;
                end
            end
            S_TRFC: begin
                if (is_nop) begin
                    gap_cnt_d = gap_inc;
                end else if (gap_cnt_q < GAP_W'(TRFC)) begin
                    fail = 1'b1; fail_code = E_TIMING;
                end else if (is_aref) begin
                    gap_cnt_d = '0;
                    ar_cnt_d  = ar_inc;
                end else if (is_mrs && (ar_cnt_q < ARC_W'(AR_MIN))) begin
                    fail = 1'b1; fail_code = E_AR_SHORT;
                end else if (is_mrs && !mode_ok) begin
                    fail = 1'b1; fail_code = E_MODE_BAD;
                end else if (is_mrs) begin
                    state_d   = S_TMRD;
                    gap_cnt_d = '0;
                    mode_d    = addr_in;
                end else begin
                    fail = 1'b1; fail_code = E_SEQ;
                end
            end
            S_TMRD: begin
                if (is_nop) begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc == GAP_W'(TMRD)) begin
                        state_d = S_READY;
                        ready_d = 1'b1;
                    end
                end else begin
                    fail = 1'b1; fail_code = E_TIMING;
                end
            end
            S_READY: ready_d = 1'b1;
            S_ERR:   err_d   = 1'b1;
            default: state_d = S_PWR;
        endcase

        if (fail) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = fail_code;
        end
    end

    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            state_q    <= S_PWR;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ar_cnt_q   <= '0;
            mode_q     <= '0;
            code_q     <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ar_cnt_q   <= ar_cnt_d;
            mode_q     <= mode_d;
            code_q     <= code_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    assign dev_ready   = ready_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign ar_count    = ar_cnt_q;
    assign mode_reg    = mode_q;
    assign cas_latency = mode_q[6:4];
    assign burst_len   = mode_q[2:0];

endmodule

// File: tb/tb_sdram_init_checker.sv
// Directed bench for sdram_init_checker: legal bring-up plus each violation class,
// with a shortened power-up wait.
module tb_sdram_init_checker;

    localparam int unsigned TW = 300;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_DES  = 4'b1010;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;
    localparam logic [3:0] C_ILL  = 4'b0110;

    logic        init_clk = 1'b0;
    logic        init_rst_n;
    logic [3:0]  cmd_in;
    logic [1:0]  bank_in;
    logic [12:0] addr_in;
    logic        dev_ready;
    logic        err;
    logic [2:0]  err_code;
    logic [3:0]  ar_count;
    logic [12:0] mode_reg;
    logic [2:0]  cas_latency;
    logic [2:0]  burst_len;

    int errors = 0;
    int checks = 0;

    sdram_init_checker #(
        .T_WAIT(TW), .TRP(2), .TRFC(7), .TMRD(3), .AR_MIN(8)
    ) dut (
        .init_clk    (init_clk),
        .init_rst_n  (init_rst_n),
        .cmd_in      (cmd_in),
        .bank_in     (bank_in),
        .addr_in     (addr_in),
        .dev_ready   (dev_ready),
        .err         (err),
        .err_code    (err_code),
        .ar_count    (ar_count),
        .mode_reg    (mode_reg),
        .cas_latency (cas_latency),
        .burst_len   (burst_len)
    );

    always #5 init_clk = ~init_clk;

    // One bus cycle: drive, let the edge sample it, settle 1 time unit.
    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        cmd_in  = c;
        bank_in = b;
        addr_in = a;
        @(posedge init_clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 3 == 2) issue(C_DES, 2'b11, 13'h1abc);
            else            issue(C_NOP, 2'b00, 13'h0000);
        end
    endtask

    task automatic do_reset();
        cmd_in     = C_NOP;
        init_rst_n = 1'b0;
        #2;
        init_rst_n = 1'b1;
    endtask

    task automatic legal_seq(input int n_aref, input logic [1:0] b, input logic [12:0] a);
        nops(TW);
        issue(C_PRE, 2'b00, 13'h1fff);
        nops(2);
        for (int i = 0; i < n_aref; i++) begin
            issue(C_AREF, 2'b00, 13'h0000);
            nops(7);
        end
        issue(C_MRS, b, a);
    endtask

    task automatic test_reset();
        init_rst_n = 1'b0;
        #1;
        checks++; if (dev_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b exp=0", dev_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", err); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL rst_code got=%0d exp=0", err_code); end
        checks++; if (ar_count !== 4'd0) begin errors++; $display("FAIL rst_ar got=%0d exp=0", ar_count); end
        checks++; if (mode_reg !== 13'h0) begin errors++; $display("FAIL rst_mode got=%0h exp=0", mode_reg); end
        checks++; if (cas_latency !== 3'd0) begin errors++; $display("FAIL rst_cl got=%0d exp=0", cas_latency); end
        checks++; if (burst_len !== 3'd0) begin errors++; $display("FAIL rst_bl got=%0d exp=0", burst_len); end
        #1;
        init_rst_n = 1'b1;
    endtask

    task automatic test_legal();
        do_reset();
        legal_seq(8, 2'b00, 13'h0037);
        nops(2);
        checks++; if (dev_ready !== 1'b0) begin errors++; $display("FAIL legal_ready_early got=%0b exp=0", dev_ready); end
        nops(1);
        checks++; if (dev_ready !== 1'b1) begin errors++; $display("FAIL legal_ready got=%0b exp=1", dev_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL legal_err got=%0b exp=0", err); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL legal_code got=%0d exp=0", err_code); end
        checks++; if (ar_count !== 4'd8) begin errors++; $display("FAIL legal_ar got=%0d exp=8", ar_count); end
        checks++; if (cas_latency !== 3'd3) begin errors++; $display("FAIL legal_cl got=%0d exp=3", cas_latency); end
        checks++; if (burst_len !== 3'd7) begin errors++; $display("FAIL legal_bl got=%0d exp=7", burst_len); end
        checks++; if (mode_reg !== 13'h0037) begin errors++; $display("FAIL legal_mode got=%0h exp=37", mode_reg); end
        issue(C_ILL, 2'b01, 13'h0000);
        issue(C_PRE, 2'b00, 13'h0000);
        checks++; if (dev_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ready_ignore got=%0b/%0b exp=1/0", dev_ready, err); end
    endtask

    task automatic test_early();
        do_reset();
        nops(99);
        issue(C_PRE, 2'b00, 13'h1fff);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL early_err got=%0b exp=1", err); end
        checks++; if (err_code !== 3'd1) begin errors++; $display("FAIL early_code got=%0d exp=1", err_code); end
        checks++; if (dev_ready !== 1'b0) begin errors++; $display("FAIL early_ready got=%0b exp=0", dev_ready); end
        do_reset();
        nops(TW - 1);
        issue(C_PRE, 2'b00, 13'h1fff);
        checks++; if (err_code !== 3'd1) begin errors++; $display("FAIL early_edge_code got=%0d exp=1", err_code); end
    endtask

    task automatic test_pwr_errors();
        do_reset();
        nops(TW);
        issue(C_PRE, 2'b00, 13'h1bff);
        checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL pre_part_code got=%0d exp=2", err_code); end
        do_reset();
        nops(TW);
        issue(C_AREF, 2'b00, 13'h0000);
        checks++; if (err_code !== 3'd3) begin errors++; $display("FAIL seq_code got=%0d exp=3", err_code); end
    endtask

    task automatic test_timing();
        do_reset();
        nops(TW);
        issue(C_PRE, 2'b00, 13'h1fff);
        nops(1);
        issue(C_AREF, 2'b00, 13'h0000);
        checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL trp_code got=%0d exp=4", err_code); end
        checks++; if (ar_count !== 4'd0) begin errors++; $display("FAIL trp_ar got=%0d exp=0", ar_count); end
        nops(10);
        issue(C_MRS, 2'b00, 13'h0037);
        checks++; if (err_code !== 3'd4 || err !== 1'b1) begin errors++; $display("FAIL first_err_kept got=%0d/%0b exp=4/1", err_code, err); end
        checks++; if (mode_reg !== 13'h0) begin errors++; $display("FAIL err_mode_frozen got=%0h exp=0", mode_reg); end
        do_reset();
        nops(TW);
        issue(C_PRE, 2'b00, 13'h1fff);
        nops(2);
        issue(C_AREF, 2'b00, 13'h0000);
        nops(6);
        issue(C_AREF, 2'b00, 13'h0000);
        checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL trfc_code got=%0d exp=4", err_code); end
        checks++; if (ar_count !== 4'd1) begin errors++; $display("FAIL trfc_ar got=%0d exp=1", ar_count); end
    endtask

    task automatic test_mrs_errors();
        do_reset();
        legal_seq(7, 2'b00, 13'h0037);
        checks++; if (err_code !== 3'd5) begin errors++; $display("FAIL ar_short_code got=%0d exp=5", err_code); end
        checks++; if (mode_reg !== 13'h0) begin errors++; $display("FAIL ar_short_mode got=%0h exp=0", mode_reg); end
        checks++; if (ar_count !== 4'd7) begin errors++; $display("FAIL ar_short_ar got=%0d exp=7", ar_count); end
        do_reset();
        legal_seq(8, 2'b00, 13'h0017);
        checks++; if (err_code !== 3'd6) begin errors++; $display("FAIL mode_cl_code got=%0d exp=6", err_code); end
        checks++; if (dev_ready !== 1'b0) begin errors++; $display("FAIL mode_cl_ready got=%0b exp=0", dev_ready); end
        do_reset();
        legal_seq(8, 2'b01, 13'h0037);
        checks++; if (err_code !== 3'd6) begin errors++; $display("FAIL mode_bank_code got=%0d exp=6", err_code); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        nops(TW);
        issue(C_PRE, 2'b00, 13'h1fff);
        nops(2);
        for (int i = 0; i < 4; i++) begin
            issue(C_AREF, 2'b00, 13'h0000);
            if (i < 3) nops(7);
        end
        nops(3);
        checks++; if (ar_count !== 4'd4) begin errors++; $display("FAIL mid_ar_before got=%0d exp=4", ar_count); end
        #2;
        init_rst_n = 1'b0;
        #1;
        checks++; if (ar_count !== 4'd0) begin errors++; $display("FAIL mid_ar_async got=%0d exp=0", ar_count); end
        checks++; if (err !== 1'b0 || dev_ready !== 1'b0) begin errors++; $display("FAIL mid_flags_async got=%0b/%0b exp=0/0", err, dev_ready); end
        #1;
        init_rst_n = 1'b1;
        nops(50);
        issue(C_PRE, 2'b00, 13'h1fff);
        checks++; if (err_code !== 3'd1) begin errors++; $display("FAIL mid_early_code got=%0d exp=1", err_code); end
        do_reset();
        legal_seq(8, 2'b00, 13'h0037);
        nops(3);
        checks++; if (dev_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL mid_relegal got=%0b/%0b exp=1/0", dev_ready, err); end
    endtask

    initial begin
        init_rst_n = 1'b1;
        cmd_in     = C_NOP;
        bank_in    = 2'b00;
        addr_in    = 13'h0;
        #2;
        test_reset();
        test_legal();
        test_early();
        test_pwr_errors();
        test_timing();
        test_mrs_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
